// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder slice.
//   state_t     : load/run FSM state encoding
//   ADDR_W_DEF  : default instruction address width
//   DATA_W_DEF  : default instruction width (legal range 9..16)
//   NOP_WORD    : instruction presented while the fetch unit is held
package imem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 12;

  // Wide enough for the largest legal DATA_W; users slice [DATA_W-1:0].
  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD_LO = 2'd1,
    LOAD_HI = 2'd2,
    COMMIT  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// Synchronous single-port instruction RAM, 2^ADDR_W x DATA_W.
// Read-first behaviour with a registered read port; contents are not reset.
//   clk   : clock
//   we    : write enable for wdata at addr
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data (mem[addr] sampled on the rising edge)
module imem_ram
  import imem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory with an in-band byte-serial program loader.
// In RUN the fetch unit reads mem[pc] with one cycle of latency. A load_start
// pulse stalls the CPU and accepts words as two bytes (low byte first) over a
// valid/ready handshake, writing each completed word in a COMMIT cycle.
//   clk          : clock
//   rst          : asynchronous reset, active-low
//   pc           : fetch address
//   instruction  : registered instruction (NOP while cpu_hold is 1)
//   cpu_hold     : stalls the fetch unit during a load
//   load_start   : pulse that begins a program load (ignored outside RUN)
//   load_valid   : load_byte is valid
//   load_byte    : program byte
//   load_last    : marks the high byte of the final word
//   load_ready   : loader accepts a byte this cycle
//   load_err     : sticky error (high bits set or address wrap), cleared on load_start
//   words_loaded : words committed by the current or most recent load
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_hold,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  // Only the bits of the high byte that fit in the word are kept.
  localparam int HI_W = DATA_W - 8;

  // A high byte is bad if any bit above the word width is set.
  function automatic logic hi_overflow(input logic [7:0] b);
    logic [7:0] mask;
    mask = 8'hFF << HI_W;
    return |(b & mask);
  endfunction

  function automatic logic [DATA_W-1:0] pack_word(input logic [HI_W-1:0] hi,
                                                  input logic [7:0]      lo);
    return {hi, lo};
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              err_q, err_d;
  logic [7:0]        lo_q, lo_d;
  logic [HI_W-1:0]   hi_q, hi_d;
  logic              last_q, last_d;
  logic              hold_q, hold_d;
  logic              inst_vld_q, inst_vld_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    words_d    = words_q;
    err_d      = err_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    last_d     = last_q;
    load_ready = 1'b0;
    ram_we     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (load_start) begin
          state_d = LOAD_LO;
          waddr_d = '0;
          words_d = '0;
          err_d   = 1'b0;
        end
      end
      LOAD_LO: begin
        load_ready = 1'b1;
        if (load_valid) begin
          lo_d    = load_byte;
          state_d = LOAD_HI;
        end
      end
      LOAD_HI: begin
        load_ready = 1'b1;
        if (load_valid) begin
          hi_d    = load_byte[HI_W-1:0];
          last_d  = load_last;
          state_d = COMMIT;
          if (hi_overflow(load_byte)) begin
            err_d = 1'b1;
          end
        end
      end
      COMMIT: begin
        ram_we  = 1'b1;
        words_d = words_q + 1'b1;
        if (last_q) begin
          state_d = RUN;
        end else begin
          // Running past the top of memory wraps and keeps loading, but flags it.
          waddr_d = waddr_q + 1'b1;
          state_d = LOAD_LO;
          if (waddr_q == '1) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase

    // Hold covers the whole load plus the first RUN cycle, during which the
    // RAM is re-reading mem[pc] so the first released instruction is fresh.
    hold_d     = (state_d != RUN) || (state_q == COMMIT);
    inst_vld_d = (state_q == RUN) && (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      waddr_q    <= '0;
      words_q    <= '0;
      err_q      <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      last_q     <= 1'b0;
      hold_q     <= 1'b0;
      inst_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      words_q    <= words_d;
      err_q      <= err_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      inst_vld_q <= inst_vld_d;
    end
  end

  // Fetch is stalled for the whole load, so the write port can own the address.
  assign ram_addr  = (state_q == COMMIT) ? waddr_q : pc;
  assign ram_wdata = pack_word(hi_q, lo_q);

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM output register is the instruction register; a registered valid
  // flag substitutes NOP during reset, hold and the cycle after a load.
  assign instruction  = inst_vld_q ? ram_rdata : NOP_WORD[DATA_W-1:0];
  assign cpu_hold     = hold_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule
